// File: rtl/pwm_dc_sequencer.sv
// Duty-cycle sequencer feeding the PWM i_DC / i_valid_DC inputs.
// Plays back a FIFO of duty values or generates a clamped linear ramp,
// issuing one value every INTERVAL+1 clocks.
module pwm_dc_sequencer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DW         = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [7:0]    addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o,
  output logic [DW-1:0] o_dc,
  output logic          o_dc_valid,
  output logic          o_irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            en_q, en_d, mode_q, mode_d, loop_q, loop_d, irq_en_q, irq_en_d;
  logic [15:0]     interval_q, interval_d;
  logic [DW-1:0]   rstart_q, rstart_d, rend_q, rend_d, rstep_q, rstep_d;
  logic            ovf_q, ovf_d, unf_q, unf_d, done_q, done_d;
  logic [15:0]     tc_q, tc_d;
  logic [DW-1:0]   cur_q, cur_d, dc_q, dc_d;
  logic            dc_valid_q, dc_valid_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     level_q, level_d;
  logic [DW-1:0]   mem_q [FIFO_DEPTH];

  logic            wr, wr_ctrl, wr_fifo, wr_status, clr;
  logic            fifo_empty, fifo_full, tick, push_ok, pop;
  logic [DW-1:0]   step_eff, cur_next;
  logic [DW:0]     sum, diff;
  logic            unused_bits;

  assign unused_bits = ^{be_i, wdata_i[31:16]};

  assign wr         = we_i & ~re_i;
  assign wr_ctrl    = wr && (addr_i == 8'h00);
  assign wr_fifo    = wr && (addr_i == 8'h08);
  assign wr_status  = wr && (addr_i == 8'h18);
  assign clr        = wr_ctrl & wdata_i[4];
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == (AW+1)'(FIFO_DEPTH));
  assign tick       = (state_q == S_RUN) && (tc_q == interval_q);

  // Next ramp value: 17-bit add/subtract clamped to RAMP_END so it never overshoots or wraps
  always_comb begin
    step_eff = (rstep_q == '0) ? DW'(1) : rstep_q;
    sum      = {1'b0, cur_q} + {1'b0, step_eff};
    diff     = {1'b0, cur_q} - {1'b0, step_eff};
    cur_next = rend_q;
    if (rstart_q <= rend_q) begin
      if (sum < {1'b0, rend_q}) cur_next = sum[DW-1:0];
    end else begin
      if (!diff[DW] && (diff > {1'b0, rend_q})) cur_next = diff[DW-1:0];
    end
  end

  // Register writes, sequencing FSM, FIFO pointers and sticky status
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    mode_d     = mode_q;
    loop_d     = loop_q;
    irq_en_d   = irq_en_q;
    interval_d = interval_q;
    rstart_d   = rstart_q;
    rend_d     = rend_q;
    rstep_d    = rstep_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    done_d     = done_q;
    tc_d       = tc_q;
    cur_d      = cur_q;
    dc_d       = dc_q;
    dc_valid_d = 1'b0;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    pop        = 1'b0;
    push_ok    = 1'b0;

    if (wr_ctrl) begin
      en_d     = wdata_i[0];
      mode_d   = wdata_i[1];
      loop_d   = wdata_i[2];
      irq_en_d = wdata_i[3];
    end
    if (wr && addr_i == 8'h04) interval_d = wdata_i[15:0];
    if (wr && addr_i == 8'h0C) rstart_d   = wdata_i[DW-1:0];
    if (wr && addr_i == 8'h10) rend_d     = wdata_i[DW-1:0];
    if (wr && addr_i == 8'h14) rstep_d    = wdata_i[DW-1:0];
    if (wr_status) begin
      ovf_d  = ovf_q  & ~wdata_i[10];
      unf_d  = unf_q  & ~wdata_i[11];
      done_d = done_q & ~wdata_i[12];
    end

    // EN is taken from the value being written so enable/disable act on the write edge
    unique case (state_q)
      S_IDLE: begin
        if (en_d) begin
          state_d = S_RUN;
          tc_d    = '0;
          cur_d   = rstart_q;
        end
      end
      S_RUN: begin
        tc_d = tick ? '0 : tc_q + 16'd1;
        if (tick) begin
          if (!mode_q) begin
            if (!fifo_empty) begin
              pop        = 1'b1;
              dc_d       = mem_q[rptr_q];
              dc_valid_d = 1'b1;
            end else begin
              unf_d = 1'b1;
            end
          end else begin
            dc_d       = cur_q;
            dc_valid_d = 1'b1;
            if (cur_q == rend_q) begin
              if (loop_q) begin
                cur_d = rstart_q;
              end else begin
                done_d  = 1'b1;
                state_d = S_DONE;
              end
            end else begin
              cur_d = cur_next;
            end
          end
        end
        if (!en_d) begin
          state_d = S_IDLE;
          tc_d    = '0;
        end
      end
      S_DONE: begin
        if (!en_d) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A full FIFO still accepts a push when the same cycle pops
    if (wr_fifo) begin
      if (!fifo_full || pop) push_ok = 1'b1;
      else                   ovf_d   = 1'b1;
    end
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop)     rptr_d = rptr_q + AW'(1);
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    if (clr) begin
      state_d    = S_IDLE;
      tc_d       = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      done_d     = 1'b0;
      dc_d       = '0;
      dc_valid_d = 1'b0;
    end
  end

  // State and register flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 1'b0;
      loop_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      interval_q <= '0;
      rstart_q   <= '0;
      rend_q     <= '0;
      rstep_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      done_q     <= 1'b0;
      tc_q       <= '0;
      cur_q      <= '0;
      dc_q       <= '0;
      dc_valid_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      loop_q     <= loop_d;
      irq_en_q   <= irq_en_d;
      interval_q <= interval_d;
      rstart_q   <= rstart_d;
      rend_q     <= rend_d;
      rstep_q    <= rstep_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      done_q     <= done_d;
      tc_q       <= tc_d;
      cur_q      <= cur_d;
      dc_q       <= dc_d;
      dc_valid_q <= dc_valid_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i[DW-1:0];
  end

  // Combinational register read-back
  always_comb begin
    rdata_o = '0;
    unique case (addr_i)
      8'h00: rdata_o = {28'd0, irq_en_q, loop_q, mode_q, en_q};
      8'h04: rdata_o = {16'd0, interval_q};
      8'h0C: rdata_o = 32'(rstart_q);
      8'h10: rdata_o = 32'(rend_q);
      8'h14: rdata_o = 32'(rstep_q);
      8'h18: rdata_o = {19'd0, done_q, unf_q, ovf_q, fifo_full, fifo_empty, 3'd0, 5'(level_q)};
      default: rdata_o = '0;
    endcase
  end

  assign o_dc       = dc_q;
  assign o_dc_valid = dc_valid_q;
  assign o_irq      = irq_en_q & (ovf_q | unf_q | done_q);

endmodule

// File: tb/tb_pwm_dc_sequencer.sv
// Self-checking bench for pwm_dc_sequencer: scoreboard of expected duty values
// checked by a pulse monitor, plus register/status checks per scenario.
module tb_pwm_dc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0, we = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = 4'hF;
  logic [31:0] rdata;
  logic [15:0] o_dc;
  logic        o_dc_valid, o_irq;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int last_cyc = 0;
  int exp_gap = 0;
  bit have_last = 0;
  logic [15:0] sb[$];

  pwm_dc_sequencer #(.FIFO_DEPTH(16), .DW(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .re_i(re), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rdata_o(rdata), .o_dc(o_dc),
    .o_dc_valid(o_dc_valid), .o_irq(o_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pulse monitor: every o_dc_valid must match the head of the scoreboard
  always @(negedge clk) begin
    logic [15:0] e;
    if (o_dc_valid) begin
      vecs++;
      if (sb.size() == 0) begin
        errs++;
        $display("FAIL unexpected_pulse: got dc=%h, expected no pulse", o_dc);
      end else begin
        e = sb.pop_front();
        if (o_dc !== e) begin
          errs++;
          $display("FAIL pulse_value: got %h, expected %h", o_dc, e);
        end
      end
      if (exp_gap != 0 && have_last) begin
        vecs++;
        if ((cyc - last_cyc) != exp_gap) begin
          errs++;
          $display("FAIL pulse_gap: got %0d, expected %0d", cyc - last_cyc, exp_gap);
        end
      end
      have_last = 1;
      last_cyc  = cyc;
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    #1 d = rdata;
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk); #1;
      n++;
    end
    vecs++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL %s_timeout: %0d pulses outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    vecs++; if (o_dc !== 16'h0) begin errs++; $display("FAIL reset_dc: got %h, expected 0", o_dc); end
    vecs++; if (o_dc_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b, expected 0", o_dc_valid); end
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL reset_irq: got %b, expected 0", o_irq); end
    rd(8'h18, d);
    vecs++; if (d !== 32'h100) begin errs++; $display("FAIL reset_status: got %h, expected 100", d); end
    rd(8'h00, d);
    vecs++; if (d !== 32'h0) begin errs++; $display("FAIL reset_ctrl: got %h, expected 0", d); end
  endtask

  task automatic test_fifo_playback();
    logic [31:0] d;
    int k;
    wr(8'h04, 32'd3);
    rd(8'h04, d);
    vecs++; if (d !== 32'd3) begin errs++; $display("FAIL interval_rb: got %h, expected 3", d); end
    wr(8'h08, 32'h10); wr(8'h08, 32'h20); wr(8'h08, 32'h30);
    rd(8'h08, d);
    vecs++; if (d !== 32'h0) begin errs++; $display("FAIL fifo_data_rd: got %h, expected 0", d); end
    rd(8'h18, d);
    vecs++; if (d !== 32'h003) begin errs++; $display("FAIL fifo_level3: got %h, expected 3", d); end
    sb.push_back(16'h10); sb.push_back(16'h20); sb.push_back(16'h30);
    exp_gap = 4; have_last = 0;
    wr(8'h00, 32'h9);
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (o_dc_valid) break;
    end
    vecs++; if (k != 4) begin errs++; $display("FAIL first_pulse_latency: got %0d, expected 4", k); end
    wait_drain(40, "fifo");
    repeat (8) @(negedge clk);
    #1;
    vecs++; if (o_dc !== 16'h30) begin errs++; $display("FAIL unf_hold_dc: got %h, expected 30", o_dc); end
    vecs++; if (o_irq !== 1'b1) begin errs++; $display("FAIL unf_irq: got %b, expected 1", o_irq); end
    rd(8'h18, d);
    vecs++; if (d !== 32'h900) begin errs++; $display("FAIL unf_status: got %h, expected 900", d); end
    wr(8'h00, 32'h10);
    #1;
    vecs++; if (o_dc !== 16'h0) begin errs++; $display("FAIL clr_dc: got %h, expected 0", o_dc); end
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL clr_irq: got %b, expected 0", o_irq); end
    exp_gap = 0;
  endtask

  task automatic test_ramp_up();
    logic [31:0] d;
    wr(8'h0C, 32'd0); wr(8'h10, 32'd100); wr(8'h14, 32'd30); wr(8'h04, 32'd0);
    sb.push_back(16'd0); sb.push_back(16'd30); sb.push_back(16'd60);
    sb.push_back(16'd90); sb.push_back(16'd100);
    exp_gap = 1; have_last = 0;
    wr(8'h00, 32'h3);
    wait_drain(30, "ramp_up");
    repeat (10) @(negedge clk);
    rd(8'h18, d);
    vecs++; if (d !== 32'h1100) begin errs++; $display("FAIL ramp_done_status: got %h, expected 1100", d); end
    vecs++; if (o_dc !== 16'd100) begin errs++; $display("FAIL ramp_done_dc: got %h, expected 64", o_dc); end
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL ramp_irq_masked: got %b, expected 0", o_irq); end
    wr(8'h00, 32'h10);
    exp_gap = 0;
  endtask

  task automatic test_ramp_down_loop();
    logic [31:0] d;
    wr(8'h0C, 32'd50); wr(8'h10, 32'd10); wr(8'h14, 32'd25); wr(8'h04, 32'd3);
    for (int i = 0; i < 7; i++) begin
      case (i % 3)
        0: sb.push_back(16'd50);
        1: sb.push_back(16'd25);
        default: sb.push_back(16'd10);
      endcase
    end
    exp_gap = 4; have_last = 0;
    wr(8'h00, 32'h7);
    wait_drain(60, "ramp_loop");
    wr(8'h00, 32'h6);
    repeat (12) @(negedge clk);
    rd(8'h18, d);
    vecs++; if (d !== 32'h100) begin errs++; $display("FAIL loop_no_done: got %h, expected 100", d); end
    wr(8'h00, 32'h10);
    exp_gap = 0;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 17; i++) wr(8'h08, 32'h100 + i);
    rd(8'h18, d);
    vecs++; if (d !== 32'h610) begin errs++; $display("FAIL ovf_status: got %h, expected 610", d); end
    wr(8'h18, 32'h400);
    rd(8'h18, d);
    vecs++; if (d !== 32'h210) begin errs++; $display("FAIL ovf_w1c: got %h, expected 210", d); end
    wr(8'h04, 32'd0);
    for (int i = 0; i < 16; i++) sb.push_back(16'h100 + 16'(i));
    exp_gap = 1; have_last = 0;
    wr(8'h00, 32'h1);
    wait_drain(60, "ovf_drain");
    repeat (6) @(negedge clk);
    rd(8'h18, d);
    vecs++; if (d !== 32'h900) begin errs++; $display("FAIL ovf_drained_status: got %h, expected 900", d); end
    wr(8'h00, 32'h10);
    exp_gap = 0;
  endtask

  task automatic test_disable_clear();
    logic [31:0] d;
    wr(8'h04, 32'd5);
    for (int i = 1; i <= 8; i++) wr(8'h08, 32'hA00 + i);
    sb.push_back(16'hA01); sb.push_back(16'hA02);
    exp_gap = 6; have_last = 0;
    wr(8'h00, 32'h1);
    wait_drain(60, "disable");
    wr(8'h00, 32'h0);
    repeat (20) @(negedge clk);
    rd(8'h18, d);
    vecs++; if (d !== 32'h006) begin errs++; $display("FAIL disable_level: got %h, expected 6", d); end
    vecs++; if (o_dc !== 16'hA02) begin errs++; $display("FAIL disable_dc_hold: got %h, expected a02", o_dc); end
    for (int i = 0; i < 11; i++) wr(8'h08, 32'hB00 + i);
    rd(8'h18, d);
    vecs++; if (d !== 32'h610) begin errs++; $display("FAIL refill_status: got %h, expected 610", d); end
    wr(8'h00, 32'h10);
    rd(8'h18, d);
    vecs++; if (d !== 32'h100) begin errs++; $display("FAIL clr_status: got %h, expected 100", d); end
    vecs++; if (o_dc !== 16'h0) begin errs++; $display("FAIL clr_dc2: got %h, expected 0", o_dc); end
    exp_gap = 0;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    wr(8'h0C, 32'h1234); wr(8'h10, 32'hFFFF); wr(8'h14, 32'd1); wr(8'h04, 32'd2);
    sb.push_back(16'h1234); sb.push_back(16'h1235);
    exp_gap = 3; have_last = 0;
    wr(8'h00, 32'hB);
    wait_drain(30, "pre_reset");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (o_dc !== 16'h0) begin errs++; $display("FAIL arst_dc: got %h, expected 0", o_dc); end
    vecs++; if (o_dc_valid !== 1'b0) begin errs++; $display("FAIL arst_valid: got %b, expected 0", o_dc_valid); end
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL arst_irq: got %b, expected 0", o_irq); end
    rd(8'h18, d);
    vecs++; if (d !== 32'h100) begin errs++; $display("FAIL arst_status: got %h, expected 100", d); end
    rd(8'h0C, d);
    vecs++; if (d !== 32'h0) begin errs++; $display("FAIL arst_rstart: got %h, expected 0", d); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    exp_gap = 0;
  endtask

  initial begin
    test_reset();
    test_fifo_playback();
    test_ramp_up();
    test_ramp_down_loop();
    test_overflow();
    test_disable_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
